// File: rtl/toom8_pointwise_sched.sv
// rtl/toom8_pointwise_sched.sv - pointwise product sequencer for a shared TOOM-8 multiplier
//
// Steps the operand-select index over the 15 evaluation points, issues each
// pair to one fixed-latency multiplier under backpressure, tracks products in
// flight and strobes each returning product into the result store. When all
// products are stored it offers them to the interpolation stage.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request a full pass (sampled only when idle)
//   busy                  high whenever a pass is in progress
//   sel_idx               operand-pair select for the evaluation mux
//   mul_issue, mul_ready  issue handshake to the multiplier
//   res_valid, res_idx    store strobe and index for the returning product
//   res_mask              products stored so far in the current pass
//   all_valid, all_ready  all-products handshake to interpolation
module toom8_pointwise_sched #(
  parameter int NUM_POINTS = 15,
  parameter int MUL_LAT    = 4,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic [IDX_W-1:0]      sel_idx,
  output logic                  mul_issue,
  input  logic                  mul_ready,
  output logic                  res_valid,
  output logic [IDX_W-1:0]      res_idx,
  output logic [NUM_POINTS-1:0] res_mask,
  output logic                  all_valid,
  input  logic                  all_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

  state_t             state;
  state_t             state_nxt;
  logic               xfer;
  logic               start_acc;
  logic               pipe_empty;
  logic [MUL_LAT-1:0] pipe_v;
  logic [IDX_W-1:0]   pipe_idx [MUL_LAT];

  assign xfer       = mul_issue & mul_ready;
  assign start_acc  = (state == S_IDLE) & start;
  assign pipe_empty = ~|pipe_v;

  // The multiplier never stalls once it has taken an operand, so the tail of
  // the tracking pipe lines up exactly with the product on its output.
  assign res_valid  = pipe_v[MUL_LAT-1];
  assign res_idx    = pipe_idx[MUL_LAT-1];

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    mul_issue = 1'b0;
    all_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mul_issue = 1'b1;
        if (mul_ready && (sel_idx == LAST_IDX)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // The last strobe sets its mask bit on the same edge the pipe empties,
        // so completion is seen one cycle after that strobe.
        if (pipe_empty && (&res_mask)) state_nxt = S_DONE;
      end
      S_DONE: begin
        all_valid = 1'b1;
        if (all_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_idx <= '0;
    end else if (start_acc) begin
      sel_idx <= '0;
    end else if (xfer) begin
      sel_idx <= (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_W'(1);
    end
  end

  // Shifts every cycle; bubbles are loaded whenever no transfer happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < MUL_LAT; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_v[0]   <= xfer;
      pipe_idx[0] <= sel_idx;
      for (int i = 1; i < MUL_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  // Held after DONE so the stored set stays visible until the next pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_mask <= '0;
    end else if (start_acc) begin
      res_mask <= '0;
    end else if (res_valid) begin
      res_mask[res_idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_toom8_pointwise_sched.sv
// tb/tb_toom8_pointwise_sched.sv - self-checking bench for toom8_pointwise_sched
module tb_toom8_pointwise_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v [3];
  logic        rdy_v   [3];
  logic        ardy_v  [3];
  logic        busy_v  [3];
  logic        issue_v [3];
  logic        rv_v    [3];
  logic        av_v    [3];
  logic [3:0]  sel_v   [3];
  logic [3:0]  ridx_v  [3];
  logic [14:0] mask_v  [3];
  logic [14:0] model_mask [3];
  int          lat_tab [3] = '{4, 1, 8};
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  toom8_pointwise_sched #(.MUL_LAT(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]),
    .sel_idx(sel_v[0]), .mul_issue(issue_v[0]), .mul_ready(rdy_v[0]),
    .res_valid(rv_v[0]), .res_idx(ridx_v[0]), .res_mask(mask_v[0]),
    .all_valid(av_v[0]), .all_ready(ardy_v[0])
  );

  toom8_pointwise_sched #(.MUL_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]),
    .sel_idx(sel_v[1]), .mul_issue(issue_v[1]), .mul_ready(rdy_v[1]),
    .res_valid(rv_v[1]), .res_idx(ridx_v[1]), .res_mask(mask_v[1]),
    .all_valid(av_v[1]), .all_ready(ardy_v[1])
  );

  toom8_pointwise_sched #(.MUL_LAT(8)) u_l8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_v[2]),
    .sel_idx(sel_v[2]), .mul_issue(issue_v[2]), .mul_ready(rdy_v[2]),
    .res_valid(rv_v[2]), .res_idx(ridx_v[2]), .res_mask(mask_v[2]),
    .all_valid(av_v[2]), .all_ready(ardy_v[2])
  );

  // Reference: the k-th issue lands on the k-th ready cycle from cycle 1,
  // product k returns lat cycles later, DONE follows the last strobe by two
  // cycles and lasts until the first cycle all_ready is high.
  task automatic run_pass(input int d, input logic [63:0] nrdy, input int ardy_from,
                          input logic [63:0] extra_start, input string name);
    int          iss [15];
    int          k, lat, t_last, d_cyc, h_cyc, cnt;
    logic        e_busy, e_issue, e_rv, e_av;
    logic [3:0]  e_sel, e_ridx;
    logic [14:0] e_mask;
    lat = lat_tab[d];
    k = 0;
    for (int c = 1; k < 15; c++) begin
      if (!(c < 64 && nrdy[c])) begin
        iss[k] = c;
        k++;
      end
    end
    t_last = iss[14];
    d_cyc  = t_last + lat + 2;
    h_cyc  = (ardy_from > d_cyc) ? ardy_from : d_cyc;
    for (int c = 0; c <= h_cyc + 4; c++) begin
      start_v[d] = (c == 0) || (c < 64 && extra_start[c]);
      rdy_v[d]   = !(c < 64 && nrdy[c]);
      ardy_v[d]  = (c >= ardy_from);
      @(negedge clk);
      e_busy  = (c >= 1) && (c <= h_cyc);
      e_issue = (c >= 1) && (c <= t_last);
      e_av    = (c >= d_cyc) && (c <= h_cyc);
      cnt = 0;
      e_rv = 1'b0;
      e_ridx = 4'd0;
      e_mask = (c == 0) ? model_mask[d] : 15'h0;
      for (int j = 0; j < 15; j++) begin
        if (iss[j] < c) cnt++;
        if (iss[j] + lat == c) begin
          e_rv = 1'b1;
          e_ridx = j[3:0];
        end
        if (c > 0 && iss[j] + lat < c) e_mask[j] = 1'b1;
      end
      e_sel = e_issue ? cnt[3:0] : 4'd0;
      checks++;
      if (busy_v[d] !== e_busy) begin
        errors++;
        $display("FAIL %s L%0d cyc %0d busy got %b want %b", name, lat, c, busy_v[d], e_busy);
      end
      checks++;
      if (issue_v[d] !== e_issue) begin
        errors++;
        $display("FAIL %s L%0d cyc %0d mul_issue got %b want %b", name, lat, c, issue_v[d], e_issue);
      end
      checks++;
      if (sel_v[d] !== e_sel) begin
        errors++;
        $display("FAIL %s L%0d cyc %0d sel_idx got %0d want %0d", name, lat, c, sel_v[d], e_sel);
      end
      checks++;
      if (rv_v[d] !== e_rv) begin
        errors++;
        $display("FAIL %s L%0d cyc %0d res_valid got %b want %b", name, lat, c, rv_v[d], e_rv);
      end
      if (e_rv) begin
        checks++;
        if (ridx_v[d] !== e_ridx) begin
          errors++;
          $display("FAIL %s L%0d cyc %0d res_idx got %0d want %0d", name, lat, c, ridx_v[d], e_ridx);
        end
      end
      checks++;
      if (mask_v[d] !== e_mask) begin
        errors++;
        $display("FAIL %s L%0d cyc %0d res_mask got %h want %h", name, lat, c, mask_v[d], e_mask);
      end
      checks++;
      if (av_v[d] !== e_av) begin
        errors++;
        $display("FAIL %s L%0d cyc %0d all_valid got %b want %b", name, lat, c, av_v[d], e_av);
      end
      @(posedge clk);
      #1;
    end
    start_v[d] = 1'b0;
    rdy_v[d]   = 1'b1;
    ardy_v[d]  = 1'b1;
    model_mask[d] = 15'h7fff;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({busy_v[d], issue_v[d], rv_v[d], av_v[d], sel_v[d], ridx_v[d], mask_v[d]} !== 26'h0) begin
        errors++;
        $display("FAIL reset L%0d outputs got %b want 0", lat_tab[d],
                 {busy_v[d], issue_v[d], rv_v[d], av_v[d], sel_v[d], ridx_v[d], mask_v[d]});
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_pass(0, 64'h0, 0, 64'h0, "basic");
  endtask

  task automatic test_backpressure();
    logic [63:0] nrdy;
    nrdy = 64'h0;
    nrdy[3] = 1'b1;
    nrdy[4] = 1'b1;
    nrdy[10] = 1'b1;
    run_pass(0, nrdy, 0, 64'h0, "backpressure");
  endtask

  task automatic test_consumer_stall();
    run_pass(0, 64'h0, 27, 64'h0, "consumer_stall");
  endtask

  task automatic test_ignored_start();
    logic [63:0] st;
    st = 64'h0;
    st[7] = 1'b1;
    st[21] = 1'b1;
    run_pass(0, 64'h0, 0, st, "ignored_start");
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 9; c++) begin
      start_v[0] = (c == 0);
      @(posedge clk);
      #1;
    end
    start_v[0] = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid busy before reset got %b want 1", busy_v[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_v[0], issue_v[0], rv_v[0], av_v[0], sel_v[0], ridx_v[0], mask_v[0]} !== 26'h0) begin
      errors++;
      $display("FAIL reset_mid outputs got %b want 0",
               {busy_v[0], issue_v[0], rv_v[0], av_v[0], sel_v[0], ridx_v[0], mask_v[0]});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) model_mask[d] = 15'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if ({rv_v[0], busy_v[0], mask_v[0]} !== 17'h0) begin
        errors++;
        $display("FAIL reset_mid_after cyc %0d rv/busy/mask got %b want 0", c,
                 {rv_v[0], busy_v[0], mask_v[0]});
      end
      @(posedge clk);
      #1;
    end
    run_pass(0, 64'h0, 0, 64'h0, "post_reset");
  endtask

  task automatic test_latency_sweep();
    run_pass(1, 64'h0, 0, 64'h0, "lat_sweep");
    run_pass(2, 64'h0, 0, 64'h0, "lat_sweep");
  endtask

  task automatic test_random();
    logic [63:0] nrdy, st;
    for (int it = 0; it < 9; it++) begin
      nrdy = 64'h0;
      st = 64'h0;
      for (int c = 1; c < 40; c++) nrdy[c] = ($urandom_range(0, 3) == 0);
      st[$urandom_range(1, 15)] = 1'b1;
      run_pass(it % 3, nrdy, int'($urandom_range(0, 45)), st, "random");
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b0;
      rdy_v[d] = 1'b1;
      ardy_v[d] = 1'b1;
      model_mask[d] = 15'h0;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_consumer_stall();
    test_ignored_start();
    test_reset_mid();
    test_latency_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
